spi_slave: RTL and testbench

SPI_SLAVE -- requirements
Module: spi_slave

---
 rtl/spi_pkg.sv | 18 +
 rtl/spi_slave_if.sv | 33 +++
 rtl/spi_sync.sv | 35 +++
 rtl/spi_slave.sv | 172 +++++++++++++++++
 tb/tb_spi_slave.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/spi_pkg.sv
// -----------------------------------------------------------------------------
// spi_pkg
// Shared definitions for the SPI slave (and its companion SPI master):
//   SPI_DATA_W      - default frame width in bits
//   SPI_SYNC_STAGES - default depth of the input synchronisers
//   spi_state_e     - two-state link FSM encoding (IDLE, ACTIVE)
// -----------------------------------------------------------------------------
package spi_pkg;

    localparam int SPI_DATA_W      = 8;
    localparam int SPI_SYNC_STAGES = 2;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } spi_state_e;

endpackage : spi_pkg

// File: rtl/spi_slave_if.sv
// -----------------------------------------------------------------------------
// spi_slave_if
// The four SPI pins between a master and a slave.
//   sclk  - serial clock, driven by the master (idles low, mode 0)
//   mosi  - master-out / slave-in data, MSB first
//   cs_n  - active-low chip select, driven by the master
//   miso  - master-in / slave-out data, MSB first, driven by the slave
// Modports:
//   master - drives sclk/mosi/cs_n, reads miso
//   slave  - reads sclk/mosi/cs_n, drives miso
// -----------------------------------------------------------------------------
interface spi_slave_if;

    logic sclk;
    logic mosi;
    logic cs_n;
    logic miso;

    modport master (
        output sclk,
        output mosi,
        output cs_n,
        input  miso
    );

    modport slave (
        input  sclk,
        input  mosi,
        input  cs_n,
        output miso
    );

endinterface : spi_slave_if

// File: rtl/spi_sync.sv
// -----------------------------------------------------------------------------
// spi_sync
// Multi-flop synchroniser for one asynchronous single-bit input.
// Parameters:
//   STAGES  - number of flops in the chain (>= 2)
//   RST_VAL - value loaded into every flop on reset
// Ports:
//   clk     - destination clock
//   reset_n - asynchronous active-low reset
//   d       - asynchronous input
//   q       - synchronised output (last flop of the chain)
// -----------------------------------------------------------------------------
module spi_sync #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            chain_q <= {STAGES{RST_VAL}};
        end else begin
            chain_q <= {chain_q[STAGES-2:0], d};
        end
    end

    assign q = chain_q[STAGES-1];

endmodule : spi_sync

// File: rtl/spi_slave.sv
// -----------------------------------------------------------------------------
// spi_slave
// Mode-0 SPI slave oversampled by the system clock. The SPI pins are
// synchronised into clk, edges are detected on the synchronised copies and a
// two-state FSM (IDLE/ACTIVE) frames the transfer on cs_n.
// Parameters:
//   DATA_W      - frame width in bits (8)
//   SYNC_STAGES - synchroniser depth per SPI input (>= 2)
// Ports:
//   clk      - system clock, rising edge
//   reset_n  - asynchronous active-low reset
//   spi      - SPI pins (slave modport): sclk, mosi, cs_n in; miso out
//   tx_data  - byte returned to the master on the next frame
//   tx_load  - one-cycle strobe capturing tx_data into the transmit buffer
//   rx_data  - last complete received byte, held until the next frame ends
//   rx_valid - one-cycle pulse when rx_data updates
//   busy     - high while selected (state ACTIVE)
// -----------------------------------------------------------------------------
module spi_slave
    import spi_pkg::*;
#(
    parameter int DATA_W      = SPI_DATA_W,
    parameter int SYNC_STAGES = SPI_SYNC_STAGES
) (
    input  logic              clk,
    input  logic              reset_n,
    spi_slave_if.slave        spi,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_load,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              busy
);

    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    // ---- stage p0: synchronisers ----
    logic sclk_s;
    logic mosi_s;
    logic cs_s;

    spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (spi.sclk),
        .q       (sclk_s)
    );

    spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (spi.mosi),
        .q       (mosi_s)
    );

    // cs_n resets high so an idle bus does not look selected.
    spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (spi.cs_n),
        .q       (cs_s)
    );

    // ---- stage p1: edge detection ----
    logic                 sclk_s_p1;
    logic                 cs_s_p1;
    // Fills with ones after reset; the cs_n synchroniser holds its reset value
    // until the whole chain has seen real pin samples. A cs_n held low across
    // reset release would otherwise look like a fresh falling edge.
    logic [SYNC_STAGES:0] sync_ready_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sclk_s_p1    <= 1'b0;
            cs_s_p1      <= 1'b1;
            sync_ready_q <= '0;
        end else begin
            sclk_s_p1    <= sclk_s;
            cs_s_p1      <= cs_s;
            sync_ready_q <= {sync_ready_q[SYNC_STAGES-1:0], 1'b1};
        end
    end

    logic sclk_rise;
    logic sclk_fall;
    logic cs_fall;
    logic cs_rise;

    assign sclk_rise = sclk_s & ~sclk_s_p1;
    assign sclk_fall = ~sclk_s & sclk_s_p1;
    assign cs_fall   = ~cs_s & cs_s_p1 & sync_ready_q[SYNC_STAGES];
    assign cs_rise   = cs_s & ~cs_s_p1;

    // ---- FSM ----
    spi_state_e state_q;
    spi_state_e state_d;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (cs_fall) state_d = ACTIVE;
            ACTIVE:  if (cs_rise) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ---- stage p2: shift registers and outputs ----
    logic [DATA_W-1:0] tx_buf;
    logic [DATA_W-1:0] tx_buf_nxt;
    logic [DATA_W-1:0] tx_sr;
    logic [DATA_W-1:0] rx_sr;
    logic [DATA_W-1:0] rx_shift;
    logic [CNT_W-1:0]  bit_cnt;

    // A load in the same cycle as a frame (re)start wins over the old buffer.
    assign tx_buf_nxt = tx_load ? tx_data : tx_buf;
    assign rx_shift   = {rx_sr[DATA_W-2:0], mosi_s};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            tx_buf   <= '0;
            tx_sr    <= '0;
            rx_sr    <= '0;
            bit_cnt  <= '0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
        end else begin
            state_q  <= state_d;
            tx_buf   <= tx_buf_nxt;
            rx_valid <= 1'b0;

            if (state_q == IDLE) begin
                if (cs_fall) begin
                    bit_cnt <= '0;
                    rx_sr   <= '0;
                    tx_sr   <= tx_buf_nxt;
                end
            end else if (cs_rise) begin
                // Deselect: abandon any partial frame.
                bit_cnt <= '0;
                rx_sr   <= '0;
                tx_sr   <= '0;
            end else begin
                if (sclk_rise) begin
                    rx_sr <= rx_shift;
                    if (bit_cnt == LAST_BIT) begin
                        bit_cnt  <= '0;
                        rx_data  <= rx_shift;
                        rx_valid <= 1'b1;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                if (sclk_fall) begin
                    // Counter at zero on a falling edge means a frame just
                    // completed: start the next one from the buffer.
                    if (bit_cnt == '0) begin
                        tx_sr <= tx_buf_nxt;
                    end else begin
                        tx_sr <= {tx_sr[DATA_W-2:0], 1'b0};
                    end
                end
            end
        end
    end

    assign busy     = (state_q == ACTIVE);
    assign spi.miso = busy & tx_sr[DATA_W-1];

endmodule : spi_slave

// File: tb/tb_spi_slave.sv
// -----------------------------------------------------------------------------
// tb_spi_slave
// Directed bench for spi_slave: a behavioural mode-0 master drives the pins,
// received bytes are checked against a scoreboard queue by a monitor, and the
// bytes shifted back on miso are checked by the master steps.
// -----------------------------------------------------------------------------
module tb_spi_slave;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [7:0] tx_data;
    logic       tx_load;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       busy;

    int n_assert = 0;
    int n_fail   = 0;
    int rx_pulses = 0;

    logic [7:0] exp_q[$];

    spi_slave_if bus ();

    spi_slave #(.DATA_W(8), .SYNC_STAGES(2)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .spi      (bus.slave),
        .tx_data  (tx_data),
        .tx_load  (tx_load),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Monitor: every rx_valid pulse pops one expected byte.
    logic prev_valid = 1'b0;
    always @(negedge clk) begin
        if (reset_n === 1'b1 && rx_valid === 1'b1) begin
            rx_pulses++;
            chk("rx_valid_width", {31'd0, prev_valid}, 32'd0);
            if (exp_q.size() == 0) begin
                chk("rx_unexpected", {24'd0, rx_data}, 32'hFFFF_FFFF);
            end else begin
                chk("rx_data", {24'd0, rx_data}, {24'd0, exp_q.pop_front()});
            end
        end
        prev_valid = (reset_n === 1'b1) ? rx_valid : 1'b0;
    end

    // Full mode-0 frame; optionally pulse tx_load while sclk is high on the
    // last bit, i.e. before the falling edge that reloads the next frame.
    task automatic frame(input logic [7:0] mo, output logic [7:0] mi,
                         input bit do_load, input logic [7:0] ld);
        for (int i = 7; i >= 0; i--) begin
            bus.mosi = mo[i];
            repeat (5) @(negedge clk);
            bus.sclk = 1'b1;
            mi[i] = bus.miso;
            if (i == 0 && do_load) begin
                tx_data = ld;
                tx_load = 1'b1;
                @(negedge clk);
                tx_load = 1'b0;
            end
            repeat (5) @(negedge clk);
            bus.sclk = 1'b0;
        end
    endtask

    task automatic partial(input logic [7:0] mo, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            bus.mosi = mo[7 - (i % 8)];
            repeat (5) @(negedge clk);
            bus.sclk = 1'b1;
            repeat (5) @(negedge clk);
            bus.sclk = 1'b0;
        end
    endtask

    task automatic load(input logic [7:0] v);
        @(negedge clk);
        tx_data = v;
        tx_load = 1'b1;
        @(negedge clk);
        tx_load = 1'b0;
    endtask

    initial begin
        logic [7:0] mi;
        int         snap;

        bus.sclk = 1'b0;
        bus.mosi = 1'b0;
        bus.cs_n = 1'b1;
        tx_data  = 8'h00;
        tx_load  = 1'b0;
        reset_n  = 1'b0;
        repeat (4) @(negedge clk);

        // Reset values
        chk("rst_miso", {31'd0, bus.miso}, 32'd0);
        chk("rst_rx_data", {24'd0, rx_data}, 32'd0);
        chk("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        reset_n = 1'b1;
        repeat (5) @(negedge clk);

        // Single frame 0xA5, slave returns 0x3C
        load(8'h3C);
        bus.cs_n = 1'b0;
        repeat (4) @(negedge clk);
        chk("busy_active", {31'd0, busy}, 32'd1);
        exp_q.push_back(8'hA5);
        frame(8'hA5, mi, 1'b0, 8'h00);
        chk("miso_a5_frame", {24'd0, mi}, 32'h3C);
        repeat (2) @(negedge clk);
        bus.cs_n = 1'b1;
        repeat (6) @(negedge clk);
        chk("busy_after_frame", {31'd0, busy}, 32'd0);
        chk("miso_deselected", {31'd0, bus.miso}, 32'd0);

        // Back-to-back frames under one select, 0x5A loaded between them
        bus.cs_n = 1'b0;
        repeat (4) @(negedge clk);
        exp_q.push_back(8'h3C);
        frame(8'h3C, mi, 1'b1, 8'h5A);
        chk("miso_b2b_first", {24'd0, mi}, 32'h3C);
        exp_q.push_back(8'hC3);
        frame(8'hC3, mi, 1'b0, 8'h00);
        chk("miso_b2b_second", {24'd0, mi}, 32'h5A);
        repeat (2) @(negedge clk);
        bus.cs_n = 1'b1;
        repeat (6) @(negedge clk);

        // Abort after 4 bits of 0xFF
        snap = rx_pulses;
        bus.cs_n = 1'b0;
        repeat (4) @(negedge clk);
        partial(8'hFF, 4);
        bus.cs_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("abort_no_rx_valid", snap, rx_pulses);
        chk("abort_rx_data_held", {24'd0, rx_data}, 32'hC3);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_miso", {31'd0, bus.miso}, 32'd0);

        // Reset mid-frame, cs_n still low at release
        bus.cs_n = 1'b0;
        repeat (4) @(negedge clk);
        partial(8'hF0, 3);
        bus.sclk = 1'b1;
        repeat (3) @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("midrst_miso", {31'd0, bus.miso}, 32'd0);
        chk("midrst_rx_data", {24'd0, rx_data}, 32'd0);
        chk("midrst_rx_valid", {31'd0, rx_valid}, 32'd0);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        repeat (3) @(negedge clk);
        bus.sclk = 1'b0;
        reset_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("postrst_busy_wait", {31'd0, busy}, 32'd0);
        chk("postrst_miso", {31'd0, bus.miso}, 32'd0);
        bus.cs_n = 1'b1;
        repeat (5) @(negedge clk);
        bus.cs_n = 1'b0;
        repeat (4) @(negedge clk);
        exp_q.push_back(8'h81);
        frame(8'h81, mi, 1'b0, 8'h00);
        chk("postrst_miso_byte", {24'd0, mi}, 32'h00);
        repeat (2) @(negedge clk);
        bus.cs_n = 1'b1;
        repeat (6) @(negedge clk);

        // sclk activity while deselected is ignored
        snap = rx_pulses;
        partial(8'hAA, 8);
        repeat (6) @(negedge clk);
        chk("idle_sclk_no_rx", snap, rx_pulses);
        chk("idle_sclk_busy", {31'd0, busy}, 32'd0);
        chk("idle_sclk_miso", {31'd0, bus.miso}, 32'd0);

        // tx_load coincident with the select detection cycle
        load(8'h11);
        bus.cs_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        tx_data = 8'h96;
        tx_load = 1'b1;
        @(negedge clk);
        tx_load = 1'b0;
        chk("busy_sel_load", {31'd0, busy}, 32'd1);
        exp_q.push_back(8'h42);
        frame(8'h42, mi, 1'b0, 8'h00);
        chk("miso_sel_load", {24'd0, mi}, 32'h96);
        repeat (2) @(negedge clk);
        bus.cs_n = 1'b1;
        repeat (8) @(negedge clk);

        chk("scoreboard_drained", exp_q.size(), 0);
        chk("rx_pulse_total", rx_pulses, 5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule : tb_spi_slave
